// File: rtl/ram_pkg.sv
// Shared widths, state encoding and fill-pattern helper for the RAM write sequencer.
package ram_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 4;
    localparam int RAM_DEPTH = 2 ** ADDR_W;

    localparam int NUM_BTN  = 2;
    localparam int BTN_WR   = 0;
    localparam int BTN_FILL = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Fill pattern: seed plus the low address bits, wrapping at the word width.
    function automatic logic [DATA_W-1:0] fill_word(input logic [DATA_W-1:0] seed,
                                                    input logic [ADDR_W-1:0] idx);
        return seed + idx[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, and a one-cycle
// pulse on each accepted rising edge of the clean level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        // Any sample that agrees with the clean level restarts the count.
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                clean_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/ram_wr_seq.sv
// RAM write sequencer: debounced single writes (manual or auto-increment address)
// and a one-press 32-word pattern fill, driving the RAM port from registers.
module ram_wr_seq
    import ram_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              btn_write,
    input  logic              btn_fill,
    input  logic              mode_auto,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ptr
);

    logic [NUM_BTN-1:0] btn_raw, btn_p;
    logic               wr_p, fill_p;

    assign btn_raw = {btn_fill, btn_write};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[i]),
            .pulse   (btn_p[i])
        );
    end

    assign wr_p   = btn_p[BTN_WR];
    assign fill_p = btn_p[BTN_FILL];

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seed_q  <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seed_q  <= seed_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Fill wins over write when both pulses land on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_p) state_d = FILL;
                     else if (wr_p) state_d = WRITE;
            WRITE:   state_d = IDLE;
            FILL:    if (idx_q == '1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are loaded on the edge that enters each state, so
    // ram_we is high for exactly the cycles spent in WRITE and FILL.
    always_comb begin
        idx_d  = idx_q;
        seed_d = seed_q;
        ptr_d  = ptr_q;
        addr_d = mode_auto ? ptr_q : sw_addr;
        din_d  = sw_data;
        we_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_p) begin
                    seed_d = sw_data;
                    idx_d  = '0;
                    addr_d = '0;
                    din_d  = fill_word(sw_data, '0);
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                end else if (wr_p) begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            WRITE: begin
                if (mode_auto) ptr_d = ptr_q + 1'b1;
            end
            FILL: begin
                if (idx_q != '1) begin
                    idx_d  = idx_q + 1'b1;
                    addr_d = idx_d;
                    din_d  = fill_word(seed_q, idx_d);
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                    ptr_d  = '0;
                end
            end
            default: ;
        endcase
    end

    assign ram_addr = addr_q;
    assign ram_din  = din_q;
    assign ram_we   = we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ptr      = ptr_q;

endmodule
